ysyx_24100029_ifu: RTL and testbench

Instruction fetch unit. Holds the PC, issues single-beat AXI4 read requests to the instruction cache, and presents each fetched instruction with its PC to the decode stage over a valid/ready handshake. It sits directly upstream of the icache, driving its `ifu_ar*` and `ifu_r*` channels, and accepts PC redirects from the execute/writeback stage.

---
 rtl/ysyx_24100029_ifu.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_24100029_ifu.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_ifu.sv
// rtl/ysyx_24100029_ifu.sv - instruction fetch unit: PC, single-beat icache reads, decode handshake (optional perf counters: YSYX_24100029_IFU_PERF_EN)
module ysyx_24100029_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    output logic [31:0] ifu_araddr,
    output logic [3:0]  ifu_arid,
    output logic [7:0]  ifu_arlen,
    output logic [2:0]  ifu_arsize,
    output logic [1:0]  ifu_arburst,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rlast,
    input  logic [3:0]  ifu_rid,
    output logic        ifu_awvalid,
    output logic [31:0] ifu_awaddr,
    output logic        ifu_wvalid,
    output logic [31:0] ifu_wdata,
    output logic        ifu_bready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault
`ifdef YSYX_24100029_IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_OUT, S_DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_q, pend_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] opc_q, opc_d;
    logic        fault_q, fault_d;
    logic [31:0] redir_target;
    logic        redir_any;
    logic        unused_inputs;

    // Fetch is read-only; the write channels are parked and rlast/rid carry no information here.
    assign ifu_arid      = 4'd0;
    assign ifu_arlen     = 8'd0;
    assign ifu_arsize    = 3'b010;
    assign ifu_arburst   = 2'b00;
    assign ifu_awvalid   = 1'b0;
    assign ifu_awaddr    = 32'd0;
    assign ifu_wvalid    = 1'b0;
    assign ifu_wdata     = 32'd0;
    assign ifu_bready    = 1'b0;
    assign unused_inputs = ^{ifu_rlast, ifu_rid};

    // Handshake outputs decode only the registered state, never an input.
    assign ifu_arvalid = (state_q == S_AR);
    assign ifu_rready  = (state_q == S_R) || (state_q == S_DROP);
    assign out_valid   = (state_q == S_OUT);
    assign ifu_araddr  = pc_q;
    assign out_inst    = inst_q;
    assign out_pc      = opc_q;
    assign out_fault   = fault_q;

    // A live redirect always wins over one remembered from earlier.
    assign redir_any    = redirect_valid || pend_q;
    assign redir_target = redirect_valid ? redirect_pc : pend_pc_q;

    // State register and fetch bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'd0;
            pend_q    <= 1'b0;
            inst_q    <= 32'd0;
            opc_q     <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pend_q    <= pend_d;
            inst_q    <= inst_d;
            opc_q     <= opc_d;
            fault_q   <= fault_d;
        end
    end

    // Next state: an accepted AR is always followed by consuming its beat, even when redirected.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        inst_d    = inst_q;
        opc_d     = opc_q;
        fault_d   = fault_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_AR;
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_AR: begin
                if (ifu_arready) begin
                    if (redirect_valid) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redirect_pc;
                        state_d   = S_DROP;
                    end else begin
                        state_d = S_R;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end
            S_R: begin
                if (ifu_rvalid) begin
                    if (redir_any) begin
                        pc_d    = redir_target;
                        pend_d  = 1'b0;
                        state_d = S_AR;
                    end else begin
                        inst_d  = ifu_rdata;
                        opc_d   = pc_q;
                        fault_d = (ifu_rresp != 2'b00);
                        state_d = S_OUT;
                    end
                end else if (redir_any) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redir_target;
                    state_d   = S_DROP;
                end
            end
            S_DROP: begin
                if (redirect_valid) pend_pc_d = redirect_pc;
                if (ifu_rvalid) begin
                    pc_d    = redir_target;
                    pend_d  = 1'b0;
                    state_d = S_AR;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_AR;
                end else if (out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_AR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef YSYX_24100029_IFU_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

    // Count delivered instructions and cycles spent waiting on the icache.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if ((state_q == S_OUT) && out_ready && !redirect_valid)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if ((state_q == S_AR) || (state_q == S_R) || (state_q == S_DROP))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100029_ifu.sv
// tb/tb_ysyx_24100029_ifu.sv - scoreboard bench for ysyx_24100029_ifu with a behavioural icache
module tb_ysyx_24100029_ifu;

    logic        clock, reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_araddr;
    logic [3:0]  ifu_arid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst;
    logic        ifu_rvalid, ifu_rready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast;
    logic [3:0]  ifu_rid;
    logic        ifu_awvalid, ifu_wvalid, ifu_bready;
    logic [31:0] ifu_awaddr, ifu_wdata;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_inst, out_pc;
`ifdef YSYX_24100029_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    ysyx_24100029_ifu dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .ifu_awvalid(ifu_awvalid), .ifu_awaddr(ifu_awaddr), .ifu_wvalid(ifu_wvalid),
        .ifu_wdata(ifu_wdata), .ifu_bready(ifu_bready),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_fault(out_fault)
`ifdef YSYX_24100029_IFU_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } out_t;

    logic [31:0] exp_ar_q[$];
    out_t        exp_out_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          ar_n = 0;
    int          ar_cyc[3];

    int          lat = 0;
    logic [31:0] fault_addr = 32'h3000_000C;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic out_t mk(input logic [31:0] pc, input logic f);
        out_t o;
        o.pc = pc; o.inst = mem_word(pc); o.fault = f;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_out_pc(input logic [31:0] pc);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(out_valid && out_pc == pc) && n < 300);
        if (n >= 300) check("timeout_out_pc", out_pc, pc);
    endtask

    task automatic wait_rready();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ifu_rready && n < 300);
        if (n >= 300) check("timeout_rready", 32'(ifu_rready), 32'd1);
    endtask

    task automatic wait_arvalid();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ifu_arvalid && n < 300);
        if (n >= 300) check("timeout_arvalid", 32'(ifu_arvalid), 32'd1);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Icache model: accepts every AR, returns one beat after lat extra cycles.
    initial begin
        logic        pending = 1'b0;
        int          cnt = 0;
        logic [31:0] addr = 32'd0;
        ifu_arready = 1'b1;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = 2'b00;
        ifu_rlast   = 1'b0;
        ifu_rid     = 4'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pending    = 1'b0;
                ifu_rvalid = 1'b0;
                ifu_rlast  = 1'b0;
            end else begin
                if (ifu_rvalid) begin
                    ifu_rvalid = 1'b0;
                    ifu_rlast  = 1'b0;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        ifu_rvalid = 1'b1;
                        ifu_rlast  = 1'b1;
                        ifu_rdata  = mem_word(addr);
                        ifu_rresp  = (addr == fault_addr) ? 2'b10 : 2'b00;
                        pending    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (ifu_arvalid && ifu_arready) begin
                    pending = 1'b1;
                    cnt     = lat;
                    addr    = ifu_araddr;
                end
            end
        end
    end

    // Monitor: pops expectations on every AR handshake and every accepted instruction.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            cycle++;
            if (ifu_arvalid && ifu_arready) begin
                if (exp_ar_q.size() == 0) begin
                    check("ar_unexpected", ifu_araddr, 32'hFFFF_FFFF);
                end else begin
                    check("ar_addr", ifu_araddr, exp_ar_q.pop_front());
                end
                if (ar_n < 3) ar_cyc[ar_n] = cycle;
                if (ar_n == 1 || ar_n == 2) check("ar_spacing", 32'(ar_cyc[ar_n] - ar_cyc[ar_n-1]), 32'd3);
                ar_n++;
            end
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_out_q.size() == 0) begin
                    check("out_unexpected", out_pc, 32'hFFFF_FFFF);
                end else begin
                    out_t e;
                    e = exp_out_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_inst", out_inst, e.inst);
                    check("out_fault", 32'(out_fault), 32'(e.fault));
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_arvalid", 32'(ifu_arvalid), 32'd0);
        check("rst_rready", 32'(ifu_rready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_araddr", ifu_araddr, 32'h3000_0000);
        check("rst_arsize", 32'(ifu_arsize), 32'd2);
        check("rst_arlen_id_burst", {ifu_arlen, ifu_arid, ifu_arburst}, 32'd0);
        check("rst_out_pc_inst", out_pc | out_inst, 32'd0);
        check("rst_out_fault", 32'(out_fault), 32'd0);
        check("rst_write_side", {ifu_awvalid, ifu_wvalid, ifu_bready}, 32'd0);
        check("rst_write_buses", ifu_awaddr | ifu_wdata, 32'd0);

        // Sequential hits, fault at 0x...0C, stall at 0x...10
        exp_ar_q.push_back(32'h3000_0000); exp_out_q.push_back(mk(32'h3000_0000, 1'b0));
        exp_ar_q.push_back(32'h3000_0004); exp_out_q.push_back(mk(32'h3000_0004, 1'b0));
        exp_ar_q.push_back(32'h3000_0008); exp_out_q.push_back(mk(32'h3000_0008, 1'b0));
        exp_ar_q.push_back(32'h3000_000C); exp_out_q.push_back(mk(32'h3000_000C, 1'b1));
        exp_ar_q.push_back(32'h3000_0010); exp_out_q.push_back(mk(32'h3000_0010, 1'b0));
        exp_ar_q.push_back(32'h3000_0014);
        @(negedge clock);
        reset = 1'b0;

        wait_out_pc(32'h3000_0010);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc", out_pc, 32'h3000_0010);
            check("stall_inst", out_inst, mem_word(32'h3000_0010));
            check("stall_no_ar", 32'(ifu_arvalid), 32'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;

        // Redirect in OUT together with out_ready voids 0x...14
        wait_out_pc(32'h3000_0014);
        exp_ar_q.push_back(32'h3000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0100;
        lat            = 10;
        @(negedge clock);
        redirect_valid = 1'b0;
`ifdef YSYX_24100029_IFU_PERF_EN
        check("perf_fetch_void", perf_fetch_cnt, 32'd5);
`endif

        // Redirect during a 10-cycle miss on 0x...100
        wait_rready();
        @(negedge clock);
        @(negedge clock);
        exp_ar_q.push_back(32'h3000_0200); exp_out_q.push_back(mk(32'h3000_0200, 1'b0));
        exp_ar_q.push_back(32'h3000_0204);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0200;
        lat            = 0;
        @(negedge clock);
        redirect_valid = 1'b0;

        // Several redirects while draining a miss; newest target wins
        wait_out_pc(32'h3000_0200);
        lat = 10;
        wait_rready();
        exp_ar_q.push_back(32'h0000_0080); exp_out_q.push_back(mk(32'h0000_0080, 1'b0));
        exp_ar_q.push_back(32'h0000_0084);
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0300;
        @(negedge clock);
        redirect_pc    = 32'h0000_0040;
        @(negedge clock);
        redirect_pc    = 32'h0000_0080;
        @(negedge clock);
        redirect_valid = 1'b0;
        lat            = 0;

        // Redirect coinciding with the AR handshake of 0x84
        wait_out_pc(32'h0000_0080);
        wait_arvalid();
        exp_ar_q.push_back(32'h3000_0400); exp_out_q.push_back(mk(32'h3000_0400, 1'b0));
        exp_ar_q.push_back(32'h3000_0404);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000_0400;
        @(negedge clock);
        redirect_valid = 1'b0;

        wait_out_pc(32'h3000_0404);
        out_ready = 1'b0;
        repeat (5) @(negedge clock);
        check("ar_queue_drained", 32'(exp_ar_q.size()), 32'd0);
        check("out_queue_drained", 32'(exp_out_q.size()), 32'd0);
`ifdef YSYX_24100029_IFU_PERF_EN
        check("perf_fetch_total", perf_fetch_cnt, 32'd8);
`endif

        // Reset while holding an instruction in OUT
        reset = 1'b1;
        exp_ar_q.push_back(32'h3000_0000);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_arvalid", 32'(ifu_arvalid), 32'd0);
        check("midrst_araddr", ifu_araddr, 32'h3000_0000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_out_pc(32'h3000_0000);
        repeat (3) @(negedge clock);
        check("post_rst_ar_drained", 32'(exp_ar_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
